// File: rtl/serial_to_parallel_stream.sv
// Packs in_width-bit serial beats into out_width-bit words behind a one-entry
// registered output stage, with compile-time bit order and a partial-word flush.
module serial_to_parallel_stream #(
   parameter int in_width  = 1,
   parameter int out_width = 8,
   parameter bit msb_first = 1'b0
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      serial_valid,
   output logic                                      serial_ready,
   input  logic [in_width-1:0]                       serial_data,
   input  logic                                      flush,
   output logic                                      parallel_valid,
   input  logic                                      parallel_ready,
   output logic [out_width-1:0]                      parallel_data,
   output logic [$clog2(out_width/in_width+1)-1:0]   parallel_beats
);

   localparam int beats   = out_width / in_width;
   localparam int cnt_w   = (beats > 1) ? $clog2(beats) : 1;
   localparam int beats_w = $clog2(beats + 1);
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

   if (in_width < 1 || out_width % in_width != 0) begin : g_bad_params
      $error("serial_to_parallel_stream: out_width must be a multiple of in_width");
   end

   logic [out_width-1:0] acc;
   logic [out_width-1:0] merged;
   logic [cnt_w-1:0]     cnt;
   logic [cnt_w-1:0]     slot_sel;
   logic                 slot_free;
   logic                 last_beat;
   logic                 accept;
   logic                 emit;

   assign slot_free = !parallel_valid || parallel_ready;
   assign last_beat = (cnt == last_cnt);

   // A waiting output only stalls the beat that would need the slot: the
   // completing beat, or any beat while a flush is pending.
   assign serial_ready = slot_free || (!last_beat && !flush);
   assign accept       = serial_valid && serial_ready;
   assign emit         = slot_free &&
                         ((accept && last_beat) || (flush && (cnt != '0 || accept)));

   assign slot_sel = msb_first ? (last_cnt - cnt) : cnt;

   always_comb begin
      // NOTE: default first so every path assigns merged and no latch is inferred.
      merged = acc;
      for (int s = 0; s < beats; s++) begin
         if (accept && slot_sel == cnt_w'(s)) begin
            merged[s*in_width +: in_width] = serial_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc            <= '0;
         cnt            <= '0;
         parallel_valid <= 1'b0;
         parallel_data  <= '0;
         parallel_beats <= '0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         if (emit) begin
            parallel_data  <= merged;
            parallel_beats <= beats_w'(cnt) + beats_w'(accept);
            parallel_valid <= 1'b1;
            acc            <= '0;
            cnt            <= '0;
         end else begin
            if (accept) begin
               acc <= merged;
               cnt <= cnt + cnt_w'(1);
            end
            // Data and beat count deliberately hold their last values here.
            if (parallel_ready) begin
               parallel_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// Directed bench for serial_to_parallel_stream: default 1->8 LSB-first instance
// plus a 4->16 MSB-first instance, expected values computed by hand.
module tb_serial_to_parallel_stream;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default instance: in_width=1, out_width=8, msb_first=0
   logic        sv = 1'b0, sd = 1'b0, fl = 1'b0, pr = 1'b1;
   logic        sr, pv;
   logic [7:0]  pd;
   logic [3:0]  pb;

   // wide instance: in_width=4, out_width=16, msb_first=1
   logic        w_sv = 1'b0, w_fl = 1'b0, w_pr = 1'b1;
   logic [3:0]  w_sd = '0;
   logic        w_sr, w_pv;
   logic [15:0] w_pd;
   logic [2:0]  w_pb;

   int n_checks = 0;
   int n_errors = 0;

   serial_to_parallel_stream dut (
      .clk(clk), .rst(rst),
      .serial_valid(sv), .serial_ready(sr), .serial_data(sd), .flush(fl),
      .parallel_valid(pv), .parallel_ready(pr),
      .parallel_data(pd), .parallel_beats(pb)
   );

   serial_to_parallel_stream #(.in_width(4), .out_width(16), .msb_first(1'b1)) dut_w (
      .clk(clk), .rst(rst),
      .serial_valid(w_sv), .serial_ready(w_sr), .serial_data(w_sd), .flush(w_fl),
      .parallel_valid(w_pv), .parallel_ready(w_pr),
      .parallel_data(w_pd), .parallel_beats(w_pb)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                            input logic [3:0] b);
      check({tag, " valid"}, 32'(pv), 32'(v));
      check({tag, " data"},  32'(pd), 32'(d));
      check({tag, " beats"}, 32'(pb), 32'(b));
   endtask

   // drive one beat on the default instance at the current negedge
   task automatic beat(input logic bit_val);
      @(negedge clk);
      sv = 1'b1;
      sd = bit_val;
   endtask

   logic [7:0]  bits;
   logic [31:0] nibs;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      check_out("reset", 1'b0, 8'h00, 4'd0);
      check("reset w_valid", 32'(w_pv), 32'd0);
      check("reset ready", 32'(sr), 32'd1);
      rst = 1'b0;

      // 1: bits 1,0,1,1,0,0,1,0 -> 0x4D
      bits = 8'h4D;
      for (int i = 0; i < 8; i++) begin
         beat(bits[i]);
         if (i == 7) check("t1 not early", 32'(pv), 32'd0);
      end
      @(negedge clk);
      sv = 1'b0;
      check_out("t1 word", 1'b1, 8'h4D, 4'd8);
      @(negedge clk);
      check_out("t1 consumed", 1'b0, 8'h4D, 4'd8);

      // 2: wide, msb_first, A,B,C,D,1,2,3,4 back to back
      nibs = 32'hABCD1234;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 4) begin
            check("t2 w1 valid", 32'(w_pv), 32'd1);
            check("t2 w1 data",  32'(w_pd), 32'hABCD);
            check("t2 w1 beats", 32'(w_pb), 32'd4);
         end
         if (i == 5) check("t2 gap valid", 32'(w_pv), 32'd0);
         w_sv = 1'b1;
         w_sd = nibs[31-4*i -: 4];
         #1 check($sformatf("t2 ready %0d", i), 32'(w_sr), 32'd1);
      end
      @(negedge clk);
      w_sv = 1'b0;
      check("t2 w2 valid", 32'(w_pv), 32'd1);
      check("t2 w2 data",  32'(w_pd), 32'h1234);
      check("t2 w2 beats", 32'(w_pb), 32'd4);

      // 3: backpressure, 0xA5 then 0x3C with parallel_ready=0
      pr = 1'b0;
      bits = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) bits = 8'h3C;
         beat(bits[i%8]);
         #1 check($sformatf("t3 ready %0d", i), 32'(sr), (i < 15) ? 32'd1 : 32'd0);
      end
      repeat (2) begin
         @(negedge clk);
         check_out("t3 held", 1'b1, 8'hA5, 4'd8);
         check("t3 stalled", 32'(sr), 32'd0);
      end
      pr = 1'b1;
      #1 check("t3 ready freed", 32'(sr), 32'd1);
      @(negedge clk);
      sv = 1'b0;
      check_out("t3 word2", 1'b1, 8'h3C, 4'd8);
      @(negedge clk);
      check("t3 drained", 32'(pv), 32'd0);

      // 4: beats 1,1,0 then flush -> 0x03 / 3; idle flush is a no-op
      beat(1'b1); beat(1'b1); beat(1'b0);
      @(negedge clk);
      sv = 1'b0;
      fl = 1'b1;
      @(negedge clk);
      fl = 1'b0;
      check_out("t4 flush", 1'b1, 8'h03, 4'd3);
      @(negedge clk);
      fl = 1'b1;
      check("t4 after", 32'(pv), 32'd0);
      @(negedge clk);
      fl = 1'b0;
      check_out("t4 idle flush", 1'b0, 8'h03, 4'd3);

      // 5: flush while output full and parallel_ready=0
      pr = 1'b0;
      for (int i = 0; i < 8; i++) beat(1'b1);
      beat(1'b1); beat(1'b0);
      @(negedge clk);
      sv = 1'b0;
      fl = 1'b1;
      #1 check("t5 ready low", 32'(sr), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check_out("t5 pending", 1'b1, 8'hFF, 4'd8);
      end
      pr = 1'b1;
      @(negedge clk);
      fl = 1'b0;
      check_out("t5 partial", 1'b1, 8'h01, 4'd2);
      @(negedge clk);
      check("t5 drained", 32'(pv), 32'd0);

      // 6: async reset after 5 beats, then clean 0x5A
      for (int i = 0; i < 5; i++) beat(1'b1);
      @(negedge clk);
      sv = 1'b0;
      #2 rst = 1'b1;
      #1 check_out("t6 async rst", 1'b0, 8'h00, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      bits = 8'h5A;
      for (int i = 0; i < 8; i++) beat(bits[i]);
      @(negedge clk);
      sv = 1'b0;
      check_out("t6 clean word", 1'b1, 8'h5A, 4'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
